// File: rtl/eq_detect_run.sv
// eq_detect_run
// Registered equality detector with run-length qualification. Each valid
// sample of din is compared against zero (mode=0) or ref_val (mode=1).
// Consecutive hits are counted in a saturating counter. A registered
// `stable` flag is high while the run has reached HOLD samples.
//
// Optional feature: define EQ_DETECT_STICKY_EN to enable the sticky `seen`
// flag. It sets when `stable` first rises and clears only on clr or reset.
// When the macro is not defined, `seen` is tied to 0 and no sticky register
// is built.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   din (and mode/ref_val) sampled this cycle
//   din        in   WIDTH-bit data under test
//   ref_val    in   WIDTH-bit compare value used when mode=1
//   mode       in   0 = compare to zero, 1 = compare to ref_val
//   clr        in   synchronous clear of run state (priority over in_valid)
//   match      out  registered result of the last valid compare
//   out_valid  out  one-cycle pulse when match/run_cnt/stable update
//   run_cnt    out  CNT_W-bit consecutive-match count, saturating
//   stable     out  run_cnt >= HOLD (registered from the next FSM state)
//   seen       out  sticky lock indicator (0 unless EQ_DETECT_STICKY_EN)
module eq_detect_run #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] ref_val,
  input  logic             mode,
  input  logic             clr,
  output logic             match,
  output logic             out_valid,
  output logic [CNT_W-1:0] run_cnt,
  output logic             stable,
  output logic             seen
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             match_next;
  logic             valid_next;
  logic             stable_next;
  logic             hit;

  assign hit = mode ? (din == ref_val) : (din == {WIDTH{1'b0}});

  // Saturating increment: at the maximum the count holds instead of wrapping.
  assign cnt_inc = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;

  always_comb begin
    state_next = state;
    cnt_next   = run_cnt;
    match_next = match;
    valid_next = 1'b0;

    if (clr) begin
      // The sample presented alongside clr is discarded.
      state_next = IDLE;
      cnt_next   = '0;
      match_next = 1'b0;
    end else if (in_valid) begin
      match_next = hit;
      valid_next = 1'b1;
      if (hit) begin
        cnt_next = cnt_inc;
        case (state)
          IDLE:    state_next = (HOLD_C == CNT_W'(1)) ? LOCKED : COUNT;
          COUNT:   state_next = (cnt_inc >= HOLD_C) ? LOCKED : COUNT;
          LOCKED:  state_next = LOCKED;
          default: state_next = IDLE;
        endcase
      end else begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    end
  end

  // stable is registered from the next state, so it never glitches with
  // run_cnt decoding.
  assign stable_next = (state_next == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_cnt   <= '0;
      match     <= 1'b0;
      out_valid <= 1'b0;
      stable    <= 1'b0;
    end else begin
      state     <= state_next;
      run_cnt   <= cnt_next;
      match     <= match_next;
      out_valid <= valid_next;
      stable    <= stable_next;
    end
  end

`ifdef EQ_DETECT_STICKY_EN
  logic seen_reg;

  // Sets together with the first rise of stable; only clr or reset clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg <= 1'b0;
    end else if (clr) begin
      seen_reg <= 1'b0;
    end else if (stable_next) begin
      seen_reg <= 1'b1;
    end
  end

  assign seen = seen_reg;
`else
  assign seen = 1'b0;
`endif

endmodule
